// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a valid/ready data-memory port and MEM/WB register.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif

module mem_stage #(
  parameter int DW = `DATAWIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic          MemtoReg,
  input  logic          RegWrite,
  input  logic [4:0]    rd,
  input  logic [DW-1:0] ALU_result,
  input  logic [DW-1:0] wr_MemData,
  input  logic [2:0]    funct3,
  output logic          dmem_req_valid,
  input  logic          dmem_req_ready,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic [3:0]    dmem_wstrb,
  input  logic          dmem_rsp_valid,
  input  logic [DW-1:0] dmem_rdata,
  output logic          mem_stall,
  output logic          RegWrite_o,
  output logic          MemtoReg_o,
  output logic [4:0]    rd_o,
  output logic [DW-1:0] ALU_result_o,
  output logic [DW-1:0] load_data_o,
  output logic          misalign_o
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_RSP = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [1:0]    off;
  logic          acc, ld_op, sz_b, sz_h, mis;
  logic          req, st_done, ld_hs, ld_done, done;
  logic [7:0]    b_sel;
  logic [15:0]   h_sel;
  logic [DW-1:0] ld_ext;

  logic          regwrite_q, regwrite_d;
  logic          memtoreg_q, memtoreg_d;
  logic          misalign_q, misalign_d;
  logic [4:0]    rd_q, rd_d;
  logic [DW-1:0] alu_q, alu_d;
  logic [DW-1:0] ldata_q, ldata_d;

  assign off   = ALU_result[1:0];
  assign acc   = MemRead | MemWrite;
  assign ld_op = ~MemWrite;

  // Unsigned byte/half encodings only exist for loads
  always_comb begin
    sz_b = 1'b0;
    sz_h = 1'b0;
    unique case (1'b1)
      (funct3 == 3'b000) || (ld_op && funct3 == 3'b100): sz_b = 1'b1;
      (funct3 == 3'b001) || (ld_op && funct3 == 3'b101): sz_h = 1'b1;
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = acc & ((sz_h & off[0]) |
               (~sz_b & ~sz_h & (off != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  assign req       = (state_q == IDLE) & acc & ~mis;
  assign st_done   = req & MemWrite & dmem_req_ready;
  assign ld_hs     = req & ld_op & dmem_req_ready;
  assign ld_done   = (state_q == WAIT_RSP) & dmem_rsp_valid;
  assign mem_stall = (req & ~st_done) |
                     ((state_q == WAIT_RSP) & ~dmem_rsp_valid);
  assign done      = ~mem_stall;

  assign dmem_req_valid = req;
  assign dmem_we        = req & MemWrite;
  assign dmem_addr      = {ALU_result[DW-1:2], 2'b00};

  always_comb begin
    dmem_wdata = wr_MemData;
    dmem_wstrb = 4'b1111;
    unique case (1'b1)
      sz_b: begin
        dmem_wdata = {4{wr_MemData[7:0]}};
        dmem_wstrb = 4'b0001 << off;
      end
      sz_h: begin
        dmem_wdata = {2{wr_MemData[15:0]}};
        dmem_wstrb = 4'b0011 << {off[1], 1'b0};
      end
      default: ;
    endcase
    if (!dmem_we) dmem_wstrb = 4'b0000;
  end

  assign b_sel = dmem_rdata[{off, 3'b000} +: 8];
  assign h_sel = dmem_rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = dmem_rdata;
    unique case (1'b1)
      sz_b: ld_ext = funct3[2] ? {24'b0, b_sel}
                               : {{24{b_sel[7]}}, b_sel};
      sz_h: ld_ext = funct3[2] ? {16'b0, h_sel}
                               : {{16{h_sel[15]}}, h_sel};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (ld_hs) state_d = WAIT_RSP;
      WAIT_RSP: if (dmem_rsp_valid) state_d = IDLE;
    endcase
  end

  // A stalled edge loads a bubble; data fields simply hold
  always_comb begin
    regwrite_d = done & RegWrite & ~mis;
    memtoreg_d = done & MemtoReg;
    misalign_d = done & mis;
    rd_d       = done ? rd : 5'd0;
    alu_d      = done ? ALU_result : alu_q;
    ldata_d    = ld_done ? ld_ext : (done ? '0 : ldata_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      misalign_q <= 1'b0;
      rd_q       <= 5'd0;
      alu_q      <= '0;
      ldata_q    <= '0;
    end else begin
      state_q    <= state_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      misalign_q <= misalign_d;
      rd_q       <= rd_d;
      alu_q      <= alu_d;
      ldata_q    <= ldata_d;
    end
  end

  assign RegWrite_o   = regwrite_q;
  assign MemtoReg_o   = memtoreg_q;
  assign misalign_o   = misalign_q;
  assign rd_o         = rd_q;
  assign ALU_result_o = alu_q;
  assign load_data_o  = ldata_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage.
// Honours MEM_MISALIGN_TRAP_EN to match the DUT build.
module tb_mem_stage;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, MemtoReg, RegWrite;
  logic [4:0]  rd;
  logic [31:0] ALU_result, wr_MemData;
  logic [2:0]  funct3;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        RegWrite_o, MemtoReg_o, misalign_o;
  logic [4:0]  rd_o;
  logic [31:0] ALU_result_o, load_data_o;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .rd(rd), .ALU_result(ALU_result),
    .wr_MemData(wr_MemData), .funct3(funct3),
    .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .rd_o(rd_o), .ALU_result_o(ALU_result_o),
    .load_data_o(load_data_o), .misalign_o(misalign_o)
  );

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        chk_ld;
    logic [31:0] ld;
    logic        mis;
  } exp_t;

  exp_t sbq[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Access size in bytes; unknown encodings are word accesses
  function automatic int sz_of(input bit st, input logic [2:0] f3);
    if (f3 == 3'd0 || (!st && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (!st && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic bit trap(input bit st, input logic [2:0] f3,
                              input logic [31:0] a);
    return TRAP_EN && ((a % sz_of(st, f3)) != 0);
  endfunction

  function automatic int lane_of(input int sz, input logic [31:0] a);
    return ((a % 4) / sz) * sz;
  endfunction

  function automatic logic [31:0] ld_model(input logic [2:0] f3,
      input logic [31:0] a, input logic [31:0] rdat);
    int sz;
    logic [31:0] v, top;
    sz = sz_of(1'b0, f3);
    if (sz == 4) return rdat;
    v = rdat >> (8 * lane_of(sz, a));
    v = v & ((sz == 1) ? 32'hFF : 32'hFFFF);
    top = (sz == 1) ? 32'h80 : 32'h8000;
    if (!f3[2] && (v & top) != 0) v = v - (top << 1);
    return v;
  endfunction

  function automatic logic [3:0] strb_model(input logic [2:0] f3,
                                            input logic [31:0] a);
    int sz;
    int m;
    sz = sz_of(1'b1, f3);
    if (sz == 4) return 4'hF;
    m = ((1 << sz) - 1) << lane_of(sz, a);
    return m[3:0];
  endfunction

  function automatic logic [31:0] wdata_model(input logic [2:0] f3,
                                              input logic [31:0] d);
    int sz;
    sz = sz_of(1'b1, f3);
    if (sz == 1) return d[7:0] * 32'h01010101;
    if (sz == 2) return d[15:0] * 32'h00010001;
    return d;
  endfunction

  task automatic set_idle();
    MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0;
    rd = 0; ALU_result = 0; wr_MemData = 0; funct3 = 0;
    dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
  endtask

  // Called just after a rising edge; returns just after the completion edge
  task automatic txn(input bit rd_en, input bit wr_en,
      input logic [2:0] f3, input logic [31:0] a,
      input logic [31:0] wdat, input logic [31:0] rdat,
      input int w_rdy, input int w_rsp,
      input logic [4:0] rdi, input bit m2r);
    bit acc, mis;
    exp_t e;
    acc = rd_en | wr_en;
    mis = acc && trap(wr_en, f3, a);
    MemRead = rd_en; MemWrite = wr_en; MemtoReg = m2r;
    RegWrite = 1'b1; rd = rdi; ALU_result = a;
    wr_MemData = wdat; funct3 = f3;
    e.rw = !mis; e.m2r = m2r; e.rd = rdi; e.alu = a;
    e.chk_ld = rd_en && !wr_en && !mis;
    e.ld = ld_model(f3, a, rdat);
    e.mis = mis;
    sbq.push_back(e);
    if (acc && !mis) begin
      for (int c = 0; c <= w_rdy; c++) begin
        dmem_req_ready = (c == w_rdy);
        dmem_rsp_valid = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        @(negedge clk);
        check("req_valid", dmem_req_valid, 1);
        check("req_addr", dmem_addr, {a[31:2], 2'b00});
        check("req_we", dmem_we, wr_en);
        check("wstrb", dmem_wstrb, wr_en ? strb_model(f3, a) : 4'h0);
        if (wr_en) check("wdata", dmem_wdata, wdata_model(f3, wdat));
        check("stall_req", mem_stall, wr_en ? (c != w_rdy) : 1);
        @(posedge clk); #1;
      end
      if (!wr_en) begin
        for (int d = 0; d <= w_rsp; d++) begin
          dmem_req_ready = 1'($urandom_range(0, 1));
          dmem_rsp_valid = (d == w_rsp);
          dmem_rdata = (d == w_rsp) ? rdat : $urandom;
          @(negedge clk);
          check("req_valid_wait", dmem_req_valid, 0);
          check("stall_wait", mem_stall, d != w_rsp);
          @(posedge clk); #1;
        end
      end
    end else begin
      dmem_req_ready = 1'($urandom_range(0, 1));
      dmem_rsp_valid = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      @(negedge clk);
      check("no_req", dmem_req_valid, 0);
      check("no_req_strb", dmem_wstrb, 0);
      check("no_stall", mem_stall, 0);
      @(posedge clk); #1;
    end
    dmem_req_ready = 0;
    dmem_rsp_valid = 0;
  endtask

  // Monitor: every MEM/WB write-back (or trap) pulse must match the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (rst === 1'b1 && (RegWrite_o === 1'b1 || misalign_o === 1'b1)) begin
        if (sbq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_wb: rd_o %h RegWrite_o %b misalign_o %b expected none",
                   rd_o, RegWrite_o, misalign_o);
        end else begin
          e = sbq.pop_front();
          check("wb_regwrite", RegWrite_o, e.rw);
          check("wb_memtoreg", MemtoReg_o, e.m2r);
          check("wb_rd", rd_o, e.rd);
          check("wb_alu", ALU_result_o, e.alu);
          check("wb_misalign", misalign_o, e.mis);
          if (e.chk_ld) check("wb_load_data", load_data_o, e.ld);
        end
      end
    end
  end

  initial begin
    set_idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_regwrite", RegWrite_o, 0);
    check("rst_memtoreg", MemtoReg_o, 0);
    check("rst_rd", rd_o, 0);
    check("rst_alu", ALU_result_o, 0);
    check("rst_load", load_data_o, 0);
    check("rst_misalign", misalign_o, 0);
    check("rst_req", dmem_req_valid, 0);
    check("rst_stall", mem_stall, 0);
    @(posedge clk); #1;

    txn(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 0, 5'd3, 0);
    txn(1, 0, 3'b000, 32'h203, 0, 32'h80112233, 2, 0, 5'd5, 1);
    txn(1, 0, 3'b101, 32'h202, 0, 32'hBEEF1234, 1, 1, 5'd6, 1);
    txn(0, 1, 3'b000, 32'h001, 32'h000000AB, 0, 1, 0, 5'd7, 0);
    txn(1, 0, 3'b010, 32'h102, 0, 32'h55AA33CC, 0, 0, 5'd8, 1);
    txn(0, 0, 3'b000, 32'h1234, 0, 0, 0, 0, 5'd9, 0);

    // Reset while waiting for a load response; the late response is dropped
    MemRead = 1; MemWrite = 0; RegWrite = 1; MemtoReg = 1;
    rd = 5'd10; ALU_result = 32'h300; funct3 = 3'b010;
    dmem_req_ready = 1;
    @(negedge clk);
    check("r29_req", dmem_req_valid, 1);
    @(posedge clk); #1;
    dmem_req_ready = 0;
    @(negedge clk);
    check("r29_stall", mem_stall, 1);
    set_idle();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    dmem_rsp_valid = 1;
    dmem_rdata = 32'h12345678;
    @(negedge clk);
    check("r29_regwrite", RegWrite_o, 0);
    check("r29_rd", rd_o, 0);
    check("r29_stall_idle", mem_stall, 0);
    check("r29_req_idle", dmem_req_valid, 0);
    @(posedge clk); #1;
    dmem_rsp_valid = 0;
    @(negedge clk);
    check("r29_regwrite2", RegWrite_o, 0);
    check("r29_load_drop", load_data_o, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(0, 2);
      txn(k == 1, k == 2, 3'($urandom_range(0, 7)), $urandom,
          $urandom, $urandom,
          $urandom_range(0, 2), $urandom_range(0, 2),
          5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)));
    end

    set_idle();
    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
